// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the fetch PC, captures instruction words into a 2-entry
// queue for decode, and handles redirects, halt-with-drain and illegal-address faults.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

  logic pop, redir, misaligned, cap_try, out_of_range, fault_now, cap;
  logic [1:0] slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      pc0_q   <= '0;
      ins0_q  <= '0;
      pc1_q   <= '0;
      ins1_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
    end
  end

  always_comb begin
    out_valid    = (count_q != 2'd0) && (state_q != S_FAULT);
    pop          = out_valid && out_ready;
    redir        = redirect_valid && (state_q != S_FAULT);
    misaligned   = redir && (redirect_pc[1:0] != 2'b00);
    cap_try      = (state_q == S_RUN) && !redirect_valid && !halt_req &&
                   ((count_q < 2'd2) || pop);
    out_of_range = {1'b0, pc_q} >= LIMIT;
    fault_now    = misaligned || (cap_try && out_of_range);
    cap          = cap_try && !out_of_range;
    slot         = count_q - {1'b0, pop};

    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;

    unique case (state_q)
      S_IDLE:   if (enable) state_d = S_RUN;
      S_RUN:    if (halt_req) state_d = S_DRAIN;
      // A redirect in DRAIN flushes the queue; the state moves on next cycle.
      S_DRAIN:  if (!redir && ((count_q == 2'd0) || (count_q == 2'd1 && pop)))
                  state_d = S_HALTED;
      S_HALTED: if (!halt_req && enable) state_d = S_RUN;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase

    if (fault_now) begin
      state_d = S_FAULT;
      count_d = '0;
      if (misaligned) pc_d = redirect_pc;
    end else if (redir) begin
      count_d = '0;
      pc_d    = redirect_pc;
    end else begin
      // Entry 0 is always the head; entries are left in place when the
      // queue empties so the head outputs hold their last values.
      if (pop && count_q == 2'd2) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
      end
      if (cap) begin
        if (slot == 2'd0) begin
          pc0_d  = pc_q;
          ins0_d = imem_rdata;
        end else begin
          pc1_d  = pc_q;
          ins1_d = imem_rdata;
        end
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, cap} - {1'b0, pop};
    end
  end

  assign imem_addr = pc_q;
  assign out_pc    = pc0_q;
  assign out_instr = ins0_q;
  assign halted    = (state_q == S_HALTED);
  assign fault     = (state_q == S_FAULT);

endmodule
